// File: rtl/led_fade_pwm_if.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_if
//   Signal bundle between the LED flasher (master) and the fade/PWM stage
//   (slave).
//
//   Signals:
//     en       master -> slave  block enable; 0 forces the fade off
//     led_in   master -> slave  LED request from the flasher (1 = lit)
//     pwm_out  slave -> master  registered PWM drive for the LED pin
//     duty     slave -> master  current linear duty value
//     state    slave -> master  fade FSM state (0 OFF, 1 UP, 2 ON, 3 DOWN)
//     busy     slave -> master  1 while the fade is ramping (UP or DOWN)
//
//   Handshake: there is no valid/ready pair. en and led_in are
//   level-sensitive and sampled on every rising clk edge; the slave never
//   stalls the master, so a request is accepted on the edge where it is seen.
// ---------------------------------------------------------------------------
interface led_fade_pwm_if #(
    parameter int PWM_BITS = 8
);
    logic                en;
    logic                led_in;
    logic                pwm_out;
    logic [PWM_BITS-1:0] duty;
    logic [1:0]          state;
    logic                busy;

    modport master (
        output en,
        output led_in,
        input  pwm_out,
        input  duty,
        input  state,
        input  busy
    );

    modport slave (
        input  en,
        input  led_in,
        output pwm_out,
        output duty,
        output state,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
//   Fades the flasher's on/off LED request in and out with a PWM output.
//   A free-running PWM counter defines the period (2^PWM_BITS clocks); once
//   per period the FSM moves the duty by STEP toward full brightness (UP) or
//   toward dark (DOWN), saturating at MAX and 0, and holds at ON / OFF.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous, active-low reset
//     bus  - led_fade_pwm_if.slave: en, led_in in; pwm_out, duty, state,
//            busy out
//
//   Parameters:
//     PWM_BITS - width of PWM counter and duty register
//     STEP     - duty change per PWM period while ramping (1 .. 2^PWM_BITS-1)
//
//   Optional feature (macro LED_FADE_GAMMA_EN):
//     defined   - PWM compare value is (duty*duty) >> PWM_BITS, re-registered
//                 at each period end (one period of extra brightness latency)
//     undefined - PWM compare value is the linear duty
// ---------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic           clk,
    input  logic           rst,
    led_fade_pwm_if.slave  bus
);
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_out_q, pwm_out_d;
    logic [PWM_BITS-1:0] duty_cmp;
    logic                period_end;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    assign period_end = (pwm_cnt_q == MAX);

    // Saturating ramp values; the sum needs one spare bit to detect overflow.
    assign up_sum  = {1'b0, duty_q} + STEP_W;
    assign duty_up = (up_sum > {1'b0, MAX}) ? MAX : up_sum[PWM_BITS-1:0];
    assign duty_dn = ({1'b0, duty_q} < STEP_W) ? '0
                                               : (duty_q - STEP_W[PWM_BITS-1:0]);

    // Next-state / duty logic. The duty step at a period end always follows
    // the state held before the edge; a led_in reversal on the same edge
    // changes the state, and the following step uses the new direction.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_out_d = (pwm_cnt_q < duty_cmp);

        if (!bus.en) begin
            state_d = S_OFF;
            duty_d  = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    duty_d = '0;
                    if (bus.led_in) state_d = S_UP;
                end
                S_UP: begin
                    if (period_end) duty_d = duty_up;
                    if (!bus.led_in)                        state_d = S_DOWN;
                    else if (period_end && duty_up == MAX)  state_d = S_ON;
                end
                S_ON: begin
                    duty_d = MAX;
                    if (!bus.led_in) state_d = S_DOWN;
                end
                S_DOWN: begin
                    if (period_end) duty_d = duty_dn;
                    if (bus.led_in)                         state_d = S_UP;
                    else if (period_end && duty_dn == '0)   state_d = S_OFF;
                end
                default: begin
                    state_d = S_OFF;
                    duty_d  = '0;
                end
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [PWM_BITS-1:0] duty_cmp_q, duty_cmp_d;

    // Squared duty is latched once per period so the compare value never
    // changes mid-period; disabling clears it so the output goes dark at once.
    always_comb begin
        duty_cmp_d = duty_cmp_q;
        if (!bus.en) begin
            duty_cmp_d = '0;
        end else if (period_end) begin
            duty_cmp_d = PWM_BITS'(({{PWM_BITS{1'b0}}, duty_q} *
                                    {{PWM_BITS{1'b0}}, duty_q}) >> PWM_BITS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) duty_cmp_q <= '0;
        else      duty_cmp_q <= duty_cmp_d;
    end

    assign duty_cmp = duty_cmp_q;
`else
    assign duty_cmp = duty_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_OFF;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign bus.pwm_out = pwm_out_q;
    assign bus.duty    = duty_q;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q == S_UP) || (state_q == S_DOWN);
endmodule

// File: tb/tb_led_fade_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_fade_pwm
//   Directed bench for led_fade_pwm with PWM_BITS=4 (period 16, MAX 15).
//   dut1 uses STEP=1, dut4 uses STEP=4 for the saturation scenario.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_led_fade_pwm;
    logic clk;
    logic rst1;
    logic rst4;

    int checks = 0;
    int errors = 0;

    int up4 [4] = '{4, 8, 12, 15};
    int st_up4 [4] = '{1, 1, 1, 2};
    int dn4 [4] = '{11, 7, 3, 0};
    int st_dn4 [4] = '{3, 3, 3, 0};

    led_fade_pwm_if #(.PWM_BITS(4)) if1 ();
    led_fade_pwm_if #(.PWM_BITS(4)) if4 ();

    led_fade_pwm #(.PWM_BITS(4), .STEP(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1.slave)
    );

    led_fade_pwm #(.PWM_BITS(4), .STEP(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_duty(input bit sel);
        return sel ? int'(if4.duty) : int'(if1.duty);
    endfunction

    function automatic int cur_pwm(input bit sel);
        return sel ? int'(if4.pwm_out) : int'(if1.pwm_out);
    endfunction

    function automatic int cur_state(input bit sel);
        return sel ? int'(if4.state) : int'(if1.state);
    endfunction

    // Advance until the duty changes (bounded); reports the edge count and the
    // number of high pwm_out samples seen in between.
    task automatic wait_step(input bit sel, output int ticks, output int highs);
        int start;
        start = cur_duty(sel);
        ticks = 0;
        highs = 0;
        do begin
            tick();
            ticks++;
            highs += cur_pwm(sel);
        end while (cur_duty(sel) == start && ticks < 40);
        check("step_wait_bounded", int'(ticks < 40), 1);
    endtask

    // One ramp step on dut1 with its expected duty and state.
    task automatic step1(input string tag, input int exp_duty, input int exp_state,
                         output int ticks, output int highs);
        wait_step(1'b0, ticks, highs);
        check({tag, "_duty"}, cur_duty(1'b0), exp_duty);
        check({tag, "_state"}, cur_state(1'b0), exp_state);
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        int ticks;
        int highs;

        rst1 = 1'b0;
        rst4 = 1'b0;
        if1.en = 1'b1;
        if1.led_in = 1'b0;
        if4.en = 1'b1;
        if4.led_in = 1'b0;

        // Reset held for three edges, then idle with led_in=0.
        repeat (3) tick();
        check("reset_duty", int'(if1.duty), 0);
        check("reset_state", int'(if1.state), 0);
        rst1 = 1'b1;
        rst4 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            check("idle_pwm", int'(if1.pwm_out), 0);
            check("idle_duty", int'(if1.duty), 0);
            check("idle_state", int'(if1.state), 0);
            check("idle_busy", int'(if1.busy), 0);
        end

        // Fade in 1..15, ON at 15.
        if1.led_in = 1'b1;
        tick();
        check("fadein_state_up", int'(if1.state), 1);
        check("fadein_busy", int'(if1.busy), 1);
        check("fadein_duty0", int'(if1.duty), 0);
        for (int d = 1; d <= 15; d++) begin
            step1("fadein", d, (d == 15) ? 2 : 1, ticks, highs);
            if (d > 1) begin
                check("fadein_period", ticks, 16);
`ifdef LED_FADE_GAMMA_EN
                check("fadein_gamma_highs", highs, ((d - 2) * (d - 2)) >> 4);
`else
                check("fadein_highs", highs, d - 1);
`endif
            end
        end
        check("on_busy", int'(if1.busy), 0);
`ifdef LED_FADE_GAMMA_EN
        repeat (16) tick();
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            highs += int'(if1.pwm_out);
        end
        check("on_gamma_highs", highs, 14);
`else
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            highs += int'(if1.pwm_out);
        end
        check("on_highs", highs, 15);
`endif

        // Fade out from ON down to OFF.
        if1.led_in = 1'b0;
        tick();
        check("fadeout_state_down", int'(if1.state), 3);
        check("fadeout_duty15", int'(if1.duty), 15);
        for (int d = 14; d >= 0; d--) begin
            step1("fadeout", d, (d == 0) ? 0 : 3, ticks, highs);
            if (d < 14) begin
                check("fadeout_period", ticks, 16);
`ifndef LED_FADE_GAMMA_EN
                check("fadeout_highs", highs, d + 1);
`endif
            end
        end
        check("off_busy", int'(if1.busy), 0);

        // Reversal during UP at duty 6.
        if1.led_in = 1'b1;
        tick();
        check("rev_state_up", int'(if1.state), 1);
        for (int d = 1; d <= 6; d++) step1("rev_up", d, 1, ticks, highs);
        if1.led_in = 1'b0;
        tick();
        check("rev_state_down", int'(if1.state), 3);
        check("rev_no_jump", int'(if1.duty), 6);
        for (int d = 5; d >= 0; d--) begin
            step1("rev_down", d, (d == 0) ? 0 : 3, ticks, highs);
`ifndef LED_FADE_GAMMA_EN
            check("rev_highs_le6", int'(highs <= 6), 1);
            if (d < 5) check("rev_highs", highs, d + 1);
`endif
        end

        // Enable kill at duty 9.
        if1.led_in = 1'b1;
        tick();
        check("kill_state_up", int'(if1.state), 1);
        for (int d = 1; d <= 9; d++) step1("kill_ramp", d, 1, ticks, highs);
        if1.en = 1'b0;
        tick();
        check("kill_state", int'(if1.state), 0);
        check("kill_duty", int'(if1.duty), 0);
        check("kill_busy", int'(if1.busy), 0);
        tick();
        check("kill_pwm", int'(if1.pwm_out), 0);
        if1.en = 1'b1;
        tick();
        check("reen_state", int'(if1.state), 1);
        check("reen_duty", int'(if1.duty), 0);
        step1("reen_first", 1, 1, ticks, highs);

        // Reset mid-ramp at duty 7.
        for (int d = 2; d <= 7; d++) step1("rstmid_ramp", d, 1, ticks, highs);
        rst1 = 1'b0;
        tick();
        check("rstmid_duty", int'(if1.duty), 0);
        check("rstmid_state", int'(if1.state), 0);
        check("rstmid_busy", int'(if1.busy), 0);
        check("rstmid_pwm", int'(if1.pwm_out), 0);
        rst1 = 1'b1;
        tick();
        check("rstmid_restart_state", int'(if1.state), 1);
        check("rstmid_restart_duty", int'(if1.duty), 0);
        step1("rstmid_first", 1, 1, ticks, highs);
        check("rstmid_cnt_cleared", ticks, 15);

        // Saturation with STEP=4.
        if4.led_in = 1'b1;
        tick();
        check("sat_state_up", int'(if4.state), 1);
        for (int i = 0; i < 4; i++) begin
            wait_step(1'b1, ticks, highs);
            check("sat_up_duty", cur_duty(1'b1), up4[i]);
            check("sat_up_state", cur_state(1'b1), st_up4[i]);
        end
        if4.led_in = 1'b0;
        tick();
        check("sat_state_down", int'(if4.state), 3);
        for (int i = 0; i < 4; i++) begin
            wait_step(1'b1, ticks, highs);
            check("sat_dn_duty", cur_duty(1'b1), dn4[i]);
            check("sat_dn_state", cur_state(1'b1), st_dn4[i]);
        end
        check("sat_off_busy", int'(if4.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
